axi_reg_mem: RTL and testbench

Synthesizable AXI4 slave memory with a secondary 32-bit REG_BUS peek/poke port, on a single clock. It acts as the backing store for DMA/Ethernet subsystem benches and FPGA prototypes. Masters use it as a memory endpoint through the AXI port. Software or the bench preloads and checks contents through the register port.

---
 rtl/axi_reg_mem.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_axi_reg_mem.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_reg_mem.sv
// AXI4 slave memory with a secondary 32-bit REG_BUS peek/poke port on one clock.
// Optional feature macro AXIMEM_ERR_EN: out-of-range accesses answer SLVERR / reg error.

package axi_reg_mem_pkg;
    localparam int unsigned AXI_AW = 64;
    localparam int unsigned AXI_DW = 64;
    localparam int unsigned AXI_IW = 5;
    localparam int unsigned AXI_UW = 1;

    typedef struct packed {
        logic [AXI_IW-1:0]   id;
        logic [AXI_AW-1:0]   addr;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
        logic                lock;
        logic [3:0]          cache;
        logic [2:0]          prot;
        logic [3:0]          qos;
        logic [3:0]          region;
        logic [5:0]          atop;
        logic [AXI_UW-1:0]   user;
    } aw_chan_t;

    typedef struct packed {
        logic [AXI_DW-1:0]   data;
        logic [AXI_DW/8-1:0] strb;
        logic                last;
        logic [AXI_UW-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [AXI_IW-1:0]   id;
        logic [AXI_AW-1:0]   addr;
        logic [7:0]          len;
        logic [2:0]          size;
        logic [1:0]          burst;
        logic                lock;
        logic [3:0]          cache;
        logic [2:0]          prot;
        logic [3:0]          qos;
        logic [3:0]          region;
        logic [AXI_UW-1:0]   user;
    } ar_chan_t;

    typedef struct packed {
        logic [AXI_IW-1:0]   id;
        logic [1:0]          resp;
        logic [AXI_UW-1:0]   user;
    } b_chan_t;

    typedef struct packed {
        logic [AXI_IW-1:0]   id;
        logic [AXI_DW-1:0]   data;
        logic [1:0]          resp;
        logic                last;
        logic [AXI_UW-1:0]   user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } axi_rsp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module axi_reg_mem #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned IdWidth   = 5,
    parameter int unsigned UserWidth = 1,
    parameter int unsigned NumWords  = 1024,
    parameter type axi_req_t = axi_reg_mem_pkg::axi_req_t,
    parameter type axi_rsp_t = axi_reg_mem_pkg::axi_rsp_t,
    parameter type reg_req_t = axi_reg_mem_pkg::reg_req_t,
    parameter type reg_rsp_t = axi_reg_mem_pkg::reg_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  axi_req_t axi_req_i,
    output axi_rsp_t axi_rsp_o,
    input  reg_req_t reg_req_i,
    output reg_rsp_t reg_rsp_o
);
    localparam int unsigned StrbWidth   = DataWidth / 8;
    localparam int unsigned OffsetWidth = $clog2(StrbWidth);
    localparam int unsigned IdxWidth    = $clog2(NumWords);
    localparam int unsigned LaneWidth   = OffsetWidth - 2;
`ifdef AXIMEM_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    logic [DataWidth-1:0] mem [NumWords];

    w_state_e             w_state_r, w_state_s;
    logic [IdWidth-1:0]   aw_id_r;
    logic [AddrWidth-1:0] w_addr_r;
    logic [7:0]           aw_len_r, w_cnt_r;
    logic [2:0]           aw_size_r;
    logic [1:0]           aw_burst_r;
    logic                 w_err_r;

    r_state_e             r_state_r, r_state_s;
    logic [IdWidth-1:0]   r_id_r;
    logic [AddrWidth-1:0] r_addr_r;
    logic [7:0]           r_len_r, r_cnt_r;
    logic [2:0]           r_size_r;
    logic [1:0]           r_burst_r;

    logic                 aw_hs_s, w_hs_s, ar_hs_s, r_hs_s, r_last_s, w_oob_s, r_oob_s;
    logic [IdxWidth-1:0]  w_idx_s, r_idx_s, reg_idx_s;
    logic [LaneWidth-1:0] reg_lane_s;
    logic                 reg_oob_s, reg_collide_s, reg_we_s;
    logic [DataWidth-1:0] reg_word_s, r_word_s;
    logic [UserWidth-1:0] user_zero_s;
    logic                 unused_s;

    assign user_zero_s = '0;
    assign unused_s    = ^{axi_req_i, reg_req_i};

    // FIXED keeps the address; INCR and WRAP both step by the beat size.
    function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] addr,
                                                       input logic [2:0] size,
                                                       input logic [1:0] burst);
        if (burst == 2'b00) return addr;
        else return addr + (AddrWidth'(1'b1) << size);
    endfunction

    function automatic logic axi_oob(input logic [AddrWidth-1:0] addr);
        return ErrEn && (addr[AddrWidth-1:OffsetWidth+IdxWidth] != '0);
    endfunction

    // Handshakes, word indices, range checks and REG/AXI write collision
    always_comb begin
        aw_hs_s       = axi_req_i.aw_valid && (w_state_r == W_IDLE);
        w_hs_s        = axi_req_i.w_valid && (w_state_r == W_DATA);
        ar_hs_s       = axi_req_i.ar_valid && (r_state_r == R_IDLE);
        r_hs_s        = axi_req_i.r_ready && (r_state_r == R_DATA);
        r_last_s      = (r_cnt_r == r_len_r);
        w_idx_s       = w_addr_r[OffsetWidth +: IdxWidth];
        r_idx_s       = r_addr_r[OffsetWidth +: IdxWidth];
        w_oob_s       = axi_oob(w_addr_r);
        r_oob_s       = axi_oob(r_addr_r);
        reg_idx_s     = reg_req_i.addr[OffsetWidth +: IdxWidth];
        reg_lane_s    = reg_req_i.addr[2 +: LaneWidth];
        reg_oob_s     = ErrEn && (reg_req_i.addr[31:OffsetWidth+IdxWidth] != '0);
        reg_collide_s = reg_req_i.valid && reg_req_i.write && w_hs_s && (reg_idx_s == w_idx_s);
        reg_we_s      = reg_req_i.valid && reg_req_i.write && !reg_collide_s && !reg_oob_s;
        reg_word_s    = mem[reg_idx_s];
        r_word_s      = mem[r_idx_s];
    end

    // Write FSM next state
    always_comb begin
        w_state_s = w_state_r;
        case (w_state_r)
            W_IDLE:  w_state_s = aw_hs_s ? W_DATA : W_IDLE;
            W_DATA:  w_state_s = (w_hs_s && (axi_req_i.w.last || (w_cnt_r == aw_len_r))) ? W_RESP : W_DATA;
            W_RESP:  w_state_s = axi_req_i.b_ready ? W_IDLE : W_RESP;
            default: w_state_s = W_IDLE;
        endcase
    end

    // Write FSM state and latched burst context
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state_r  <= W_IDLE;
            aw_id_r    <= '0;
            w_addr_r   <= '0;
            aw_len_r   <= 8'd0;
            aw_size_r  <= 3'd0;
            aw_burst_r <= 2'd0;
            w_cnt_r    <= 8'd0;
            w_err_r    <= 1'b0;
        end else begin
            w_state_r <= w_state_s;
            if (aw_hs_s) begin
                aw_id_r    <= axi_req_i.aw.id;
                w_addr_r   <= axi_req_i.aw.addr;
                aw_len_r   <= axi_req_i.aw.len;
                aw_size_r  <= axi_req_i.aw.size;
                aw_burst_r <= axi_req_i.aw.burst;
                w_cnt_r    <= 8'd0;
                w_err_r    <= 1'b0;
            end else if (w_hs_s) begin
                w_addr_r <= next_addr(w_addr_r, aw_size_r, aw_burst_r);
                w_cnt_r  <= w_cnt_r + 8'd1;
                w_err_r  <= w_err_r | w_oob_s;
            end
        end
    end

    // Read FSM next state
    always_comb begin
        r_state_s = r_state_r;
        case (r_state_r)
            R_IDLE:  r_state_s = ar_hs_s ? R_DATA : R_IDLE;
            R_DATA:  r_state_s = (r_hs_s && r_last_s) ? R_IDLE : R_DATA;
            default: r_state_s = R_IDLE;
        endcase
    end

    // Read FSM state and latched burst context
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state_r <= R_IDLE;
            r_id_r    <= '0;
            r_addr_r  <= '0;
            r_len_r   <= 8'd0;
            r_size_r  <= 3'd0;
            r_burst_r <= 2'd0;
            r_cnt_r   <= 8'd0;
        end else begin
            r_state_r <= r_state_s;
            if (ar_hs_s) begin
                r_id_r    <= axi_req_i.ar.id;
                r_addr_r  <= axi_req_i.ar.addr;
                r_len_r   <= axi_req_i.ar.len;
                r_size_r  <= axi_req_i.ar.size;
                r_burst_r <= axi_req_i.ar.burst;
                r_cnt_r   <= 8'd0;
            end else if (r_hs_s) begin
                r_addr_r <= next_addr(r_addr_r, r_size_r, r_burst_r);
                r_cnt_r  <= r_cnt_r + 8'd1;
            end
        end
    end

    // Storage: AXI beat and REG lane writes never hit the same word in one cycle
    always_ff @(posedge clk_i) begin
        if (w_hs_s && !w_oob_s) begin
            for (int b = 0; b < StrbWidth; b++) begin
                if (axi_req_i.w.strb[b]) mem[w_idx_s][8*b +: 8] <= axi_req_i.w.data[8*b +: 8];
            end
        end
        if (reg_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (reg_req_i.wstrb[b]) mem[reg_idx_s][32*reg_lane_s + 8*b +: 8] <= reg_req_i.wdata[8*b +: 8];
            end
        end
    end

    // AXI response channels, all fields zero while not valid
    always_comb begin
        axi_rsp_o          = '0;
        axi_rsp_o.aw_ready = (w_state_r == W_IDLE);
        axi_rsp_o.w_ready  = (w_state_r == W_DATA);
        axi_rsp_o.ar_ready = (r_state_r == R_IDLE);
        axi_rsp_o.b_valid  = (w_state_r == W_RESP);
        axi_rsp_o.b.id     = (w_state_r == W_RESP) ? aw_id_r : '0;
        axi_rsp_o.b.resp   = ((w_state_r == W_RESP) && w_err_r) ? 2'b10 : 2'b00;
        axi_rsp_o.b.user   = user_zero_s;
        axi_rsp_o.r_valid  = (r_state_r == R_DATA);
        axi_rsp_o.r.id     = (r_state_r == R_DATA) ? r_id_r : '0;
        axi_rsp_o.r.data   = ((r_state_r == R_DATA) && !r_oob_s) ? r_word_s : '0;
        axi_rsp_o.r.resp   = ((r_state_r == R_DATA) && r_oob_s) ? 2'b10 : 2'b00;
        axi_rsp_o.r.last   = (r_state_r == R_DATA) && r_last_s;
        axi_rsp_o.r.user   = user_zero_s;
    end

    // REG response is combinational; a colliding write is held off one cycle
    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.ready = reg_req_i.valid && !reg_collide_s;
        reg_rsp_o.error = reg_req_i.valid && reg_oob_s;
        reg_rsp_o.rdata = (reg_req_i.valid && !reg_oob_s) ? reg_word_s[32*reg_lane_s +: 32] : 32'd0;
    end
endmodule

// File: tb/tb_axi_reg_mem.sv
// Self-checking bench for axi_reg_mem against a byte-array reference model.
module tb_axi_reg_mem;
    import axi_reg_mem_pkg::*;

    localparam int NW        = 1024;
    localparam int MEM_BYTES = NW * 8;
`ifdef AXIMEM_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic     clk = 1'b0;
    logic     rst = 1'b1;
    axi_req_t axi_req;
    axi_rsp_t axi_rsp;
    reg_req_t reg_req;
    reg_rsp_t reg_rsp;
    int       tests = 0;
    int       fails = 0;
    logic [7:0] mb [MEM_BYTES];

    axi_reg_mem dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .axi_req_i (axi_req),
        .axi_rsp_o (axi_rsp),
        .reg_req_i (reg_req),
        .reg_rsp_o (reg_rsp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int word_base(input logic [63:0] a);
        return int'((a >> 3) % 64'(NW)) * 8;
    endfunction

    function automatic logic [63:0] model_word(input logic [63:0] a);
        logic [63:0] v;
        int base;
        base = word_base(a);
        for (int b = 0; b < 8; b++) v[8*b +: 8] = mb[base + b];
        return v;
    endfunction

    function automatic bit oob(input logic [63:0] a);
        return ERR && (a >= 64'(MEM_BYTES));
    endfunction

    function automatic logic [63:0] step_addr(input logic [63:0] a, input int size, input int burst);
        return (burst == 0) ? a : a + (64'd1 << size);
    endfunction

    task automatic model_axi(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        int base;
        base = word_base(a);
        if (!oob(a)) for (int b = 0; b < 8; b++) if (s[b]) mb[base + b] = d[8*b +: 8];
    endtask

    task automatic model_reg(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int base;
        base = word_base({32'd0, a}) + (a[2] ? 4 : 0);
        if (!oob({32'd0, a})) for (int b = 0; b < 4; b++) if (s[b]) mb[base + b] = d[8*b +: 8];
    endtask

    task automatic reg_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(posedge clk); #1;
        reg_req.valid = 1'b1; reg_req.write = 1'b1;
        reg_req.addr = a; reg_req.wdata = d; reg_req.wstrb = s;
        @(negedge clk);
        check("reg_wr_ready", reg_rsp.ready, 64'd1);
        check("reg_wr_error", reg_rsp.error, 64'(oob({32'd0, a})));
        @(posedge clk); #1;
        reg_req = '0;
        model_reg(a, d, s);
    endtask

    task automatic reg_read(input logic [31:0] a);
        logic [63:0] w;
        logic [31:0] exp;
        @(posedge clk); #1;
        reg_req.valid = 1'b1; reg_req.write = 1'b0; reg_req.addr = a;
        @(negedge clk);
        w   = model_word({32'd0, a});
        exp = oob({32'd0, a}) ? 32'd0 : (a[2] ? w[63:32] : w[31:0]);
        check("reg_rd_ready", reg_rsp.ready, 64'd1);
        check("reg_rd_data", reg_rsp.rdata, 64'(exp));
        check("reg_rd_error", reg_rsp.error, 64'(oob({32'd0, a})));
        @(posedge clk); #1;
        reg_req = '0;
    endtask

    // data_mode: 0 random, 1 beat index, 2 constant d0
    task automatic axi_write(input logic [63:0] addr, input int len, input int size, input int burst,
                             input int data_mode, input logic [63:0] d0, input logic [7:0] strb0,
                             input bit rand_strb, input logic [5:0] atop);
        logic [63:0] cur, d;
        logic [7:0]  s;
        logic [4:0]  id;
        bit          err;
        err = 1'b0;
        id  = 5'($urandom);
        @(posedge clk); #1;
        axi_req.aw_valid = 1'b1; axi_req.aw.id = id; axi_req.aw.addr = addr;
        axi_req.aw.len = 8'(len); axi_req.aw.size = 3'(size); axi_req.aw.burst = 2'(burst);
        axi_req.aw.atop = atop;
        @(negedge clk);
        check("aw_ready", axi_rsp.aw_ready, 64'd1);
        @(posedge clk); #1;
        axi_req.aw_valid = 1'b0;
        cur = addr;
        for (int i = 0; i <= len; i++) begin
            d = (data_mode == 1) ? 64'(i) : (data_mode == 2) ? d0 : {$urandom, $urandom};
            s = rand_strb ? 8'($urandom) : strb0;
            axi_req.w_valid = 1'b1; axi_req.w.data = d; axi_req.w.strb = s;
            axi_req.w.last = (i == len);
            @(negedge clk);
            check("w_ready", axi_rsp.w_ready, 64'd1);
            check("b_early", axi_rsp.b_valid, 64'd0);
            @(posedge clk); #1;
            if (oob(cur)) err = 1'b1;
            model_axi(cur, d, s);
            cur = step_addr(cur, size, burst);
        end
        axi_req.w_valid = 1'b0; axi_req.w.last = 1'b0;
        @(negedge clk);
        check("b_valid", axi_rsp.b_valid, 64'd1);
        check("b_id", axi_rsp.b.id, 64'(id));
        check("b_resp", axi_rsp.b.resp, err ? 64'd2 : 64'd0);
        check("w_ready_off", axi_rsp.w_ready, 64'd0);
        axi_req.b_ready = 1'b1;
        @(posedge clk); #1;
        axi_req.b_ready = 1'b0; axi_req.aw.atop = 6'd0;
        @(negedge clk);
        check("b_clear", axi_rsp.b_valid, 64'd0);
    endtask

    // mode: 0 r_ready held, 1 r_ready toggling (starts stalled), 2 random
    task automatic axi_read(input logic [63:0] addr, input int len, input int size, input int burst,
                            input int mode);
        logic [63:0] cur, exp;
        logic [4:0]  id;
        int          beat, cyc;
        bit          rr;
        beat = 0; cyc = 0;
        id   = 5'($urandom);
        @(posedge clk); #1;
        axi_req.ar_valid = 1'b1; axi_req.ar.id = id; axi_req.ar.addr = addr;
        axi_req.ar.len = 8'(len); axi_req.ar.size = 3'(size); axi_req.ar.burst = 2'(burst);
        @(negedge clk);
        check("ar_ready", axi_rsp.ar_ready, 64'd1);
        check("r_early", axi_rsp.r_valid, 64'd0);
        @(posedge clk); #1;
        axi_req.ar_valid = 1'b0;
        cur = addr;
        while (beat <= len && cyc < 64) begin
            rr = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 1) : 1'($urandom_range(0, 1));
            axi_req.r_ready = rr;
            @(negedge clk);
            exp = oob(cur) ? 64'd0 : model_word(cur);
            check("r_valid", axi_rsp.r_valid, 64'd1);
            check("r_data", axi_rsp.r.data, exp);
            check("r_last", axi_rsp.r.last, 64'(beat == len));
            check("r_resp", axi_rsp.r.resp, oob(cur) ? 64'd2 : 64'd0);
            check("r_id", axi_rsp.r.id, 64'(id));
            @(posedge clk); #1;
            if (rr) begin
                beat++;
                cur = step_addr(cur, size, burst);
            end
            cyc++;
        end
        axi_req.r_ready = 1'b0;
        check("rd_beats", 64'(beat), 64'(len + 1));
        @(negedge clk);
        check("r_done", axi_rsp.r_valid, 64'd0);
        check("ar_ready_back", axi_rsp.ar_ready, 64'd1);
    endtask

    initial begin
        logic [63:0] a;
        int          op, ln, sz, bu;
        axi_req = '0;
        reg_req = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_aw_ready", axi_rsp.aw_ready, 64'd1);
        check("rst_ar_ready", axi_rsp.ar_ready, 64'd1);
        check("rst_w_ready", axi_rsp.w_ready, 64'd0);
        check("rst_b_valid", axi_rsp.b_valid, 64'd0);
        check("rst_r_valid", axi_rsp.r_valid, 64'd0);
        check("rst_r_data", axi_rsp.r.data, 64'd0);
        check("rst_reg_ready", reg_rsp.ready, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int w = 0; w < 64; w++) begin
            reg_write(32'(w * 8), $urandom, 4'hF);
            reg_write(32'(w * 8 + 4), $urandom, 4'hF);
        end

        reg_write(32'h0, 32'h98001032, 4'hF);
        reg_write(32'h4, 32'h00002070, 4'hF);
        axi_read(64'h0, 0, 3, 1, 0);

        axi_write(64'h0, 7, 3, 1, 1, 64'd0, 8'hFF, 1'b0, 6'd0);
        for (int i = 0; i < 16; i++) reg_read(32'(i * 4));

        axi_write(64'h100, 0, 3, 1, 2, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 6'd0);
        axi_write(64'h100, 0, 3, 1, 2, 64'h1234_5678_9ABC_DEF0, 8'h0F, 1'b0, 6'd0);
        axi_read(64'h100, 0, 3, 1, 0);
        reg_read(32'h104);

        axi_read(64'h0, 3, 3, 1, 1);

        // AXI W beat and REG write to the same word in the same cycle
        @(posedge clk); #1;
        axi_req.aw_valid = 1'b1; axi_req.aw.id = 5'd3; axi_req.aw.addr = 64'd160;
        axi_req.aw.len = 8'd0; axi_req.aw.size = 3'd3; axi_req.aw.burst = 2'd1;
        @(posedge clk); #1;
        axi_req.aw_valid = 1'b0;
        axi_req.w_valid = 1'b1; axi_req.w.data = 64'hA5A5_5A5A_C3C3_3C3C;
        axi_req.w.strb = 8'hFF; axi_req.w.last = 1'b1;
        reg_req.valid = 1'b1; reg_req.write = 1'b1; reg_req.addr = 32'd164;
        reg_req.wdata = 32'hDEAD_BEEF; reg_req.wstrb = 4'hF;
        @(negedge clk);
        check("col_w_ready", axi_rsp.w_ready, 64'd1);
        check("col_reg_stall", reg_rsp.ready, 64'd0);
        @(posedge clk); #1;
        axi_req.w_valid = 1'b0; axi_req.w.last = 1'b0;
        model_axi(64'd160, 64'hA5A5_5A5A_C3C3_3C3C, 8'hFF);
        @(negedge clk);
        check("col_reg_retry", reg_rsp.ready, 64'd1);
        check("col_b_valid", axi_rsp.b_valid, 64'd1);
        axi_req.b_ready = 1'b1;
        @(posedge clk); #1;
        reg_req = '0; axi_req.b_ready = 1'b0;
        model_reg(32'd164, 32'hDEAD_BEEF, 4'hF);
        reg_read(32'd164);
        reg_read(32'd160);

        axi_write(64'h180, 0, 3, 1, 0, 64'd0, 8'hFF, 1'b0, 6'h20);
        check("atop_no_r", axi_rsp.r_valid, 64'd0);
        reg_read(32'h180);
        reg_read(32'h184);

        axi_read(64'(MEM_BYTES), 0, 3, 1, 0);
        reg_read(32'(MEM_BYTES + 4));

        axi_write(64'h40, 3, 3, 0, 0, 64'd0, 8'hFF, 1'b1, 6'd0);
        axi_read(64'h40, 3, 3, 0, 2);

        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 3);
            a  = 64'($urandom_range(0, 55 * 8));
            ln = $urandom_range(0, 7);
            sz = $urandom_range(0, 3);
            bu = $urandom_range(0, 2);
            case (op)
                0:       axi_write(a, ln, sz, bu, 0, 64'd0, 8'hFF, 1'b1, 6'd0);
                1:       axi_read(a, ln, sz, bu, 2);
                2:       reg_write(32'(a), $urandom, 4'($urandom));
                default: reg_read(32'(a));
            endcase
        end

        // Reset in the middle of a write burst and an open read burst
        @(posedge clk); #1;
        axi_req.aw_valid = 1'b1; axi_req.aw.id = 5'd9; axi_req.aw.addr = 64'd80;
        axi_req.aw.len = 8'd3; axi_req.aw.size = 3'd3; axi_req.aw.burst = 2'd1;
        @(posedge clk); #1;
        axi_req.aw_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            axi_req.w_valid = 1'b1; axi_req.w.data = {$urandom, $urandom};
            axi_req.w.strb = 8'hFF; axi_req.w.last = 1'b0;
            if (i == 1) begin
                axi_req.ar_valid = 1'b1; axi_req.ar.addr = 64'd0; axi_req.ar.len = 8'd3;
                axi_req.ar.size = 3'd3; axi_req.ar.burst = 2'd1;
            end
            @(posedge clk); #1;
            model_axi(64'(80 + 8 * i), axi_req.w.data, 8'hFF);
        end
        axi_req.w_valid = 1'b0; axi_req.ar_valid = 1'b0;
        check("pre_rst_r_valid", axi_rsp.r_valid, 64'd1);
        check("pre_rst_w_ready", axi_rsp.w_ready, 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_aw_ready", axi_rsp.aw_ready, 64'd1);
        check("mid_rst_w_ready", axi_rsp.w_ready, 64'd0);
        check("mid_rst_b_valid", axi_rsp.b_valid, 64'd0);
        check("mid_rst_r_valid", axi_rsp.r_valid, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        reg_read(32'd80);
        reg_read(32'd84);
        reg_read(32'd88);
        axi_write(64'd96, 0, 3, 1, 0, 64'd0, 8'hFF, 1'b0, 6'd0);
        axi_read(64'd80, 2, 3, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
